rpn_rx_sequencer: RTL and testbench

Command sequencer between the UART receiver and the RPN stack/ALU datapath. Consumes received bytes (8-bit data plus 1-cycle ready pulse) and parses ASCII decimal numbers, operators and line terminators. Issues PUSH / OP / EVAL commands to the stack over a valid/ready handshake, one command at a time. Flags bad characters, number overflow and bytes lost while a command is stalled.

---
 rtl/rpn_rx_sequencer.sv | 158 +++++++++++++++
 tb/tb_rpn_rx_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_rx_sequencer.sv
// rtl/rpn_rx_sequencer.sv - parses UART bytes into PUSH/OP/EVAL commands for the RPN stack
// Decimal accumulator, operator latch and a one-deep follow-on slot after PUSH.
module rpn_rx_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_type,
  output logic [1:0]       cmd_op,
  output logic [WIDTH-1:0] cmd_data,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NUM  = 3'd1;
  localparam logic [2:0] S_PUSH = 3'd2;
  localparam logic [2:0] S_OP   = 3'd3;
  localparam logic [2:0] S_EVAL = 3'd4;

  localparam logic [1:0] PEND_NONE = 2'd0;
  localparam logic [1:0] PEND_OP   = 2'd1;
  localparam logic [1:0] PEND_EVAL = 2'd2;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       pend_q, pend_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             is_digit, is_space, is_op, is_term;
  logic [1:0]       op_code;
  logic [WIDTH+3:0] acc_ext, acc_next;
  logic             acc_wrap;

  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_space = (rx_data == 8'h20);
    is_term  = (rx_data == 8'h0A) || (rx_data == 8'h0D);
    is_op    = 1'b1;
    op_code  = 2'd0;
    case (rx_data)
      8'h2B:   op_code = 2'd0;
      8'h2D:   op_code = 2'd1;
      8'h2A:   op_code = 2'd2;
      8'h2F:   op_code = 2'd3;
      default: is_op = 1'b0;
    endcase
    // acc*10 + d evaluated with 4 spare bits so overflow is visible in the top nibble
    acc_ext  = {4'b0000, acc_q};
    acc_next = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, rx_data[3:0]};
    acc_wrap = |acc_next[WIDTH+3:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    op_d       = op_q;
    pend_d     = pend_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE, S_NUM: begin
        if (rx_ready) begin
          if (is_digit) begin
            if (state_q == S_IDLE) begin
              acc_d   = {{(WIDTH-4){1'b0}}, rx_data[3:0]};
              ovf_d   = 1'b0;
              state_d = S_NUM;
            end else if (ovf_q || acc_wrap) begin
              ovf_d = 1'b1;
            end else begin
              acc_d = acc_next[WIDTH-1:0];
            end
          end else if (is_space || is_op || is_term) begin
            if (is_op) op_d = op_code;
            if (state_q == S_NUM && ovf_q) begin
              err_d      = 1'b1;
              err_code_d = 2'd2;
              acc_d      = '0;
              ovf_d      = 1'b0;
              state_d    = is_op ? S_OP : (is_term ? S_EVAL : S_IDLE);
            end else if (state_q == S_NUM) begin
              state_d = S_PUSH;
              pend_d  = is_op ? PEND_OP : (is_term ? PEND_EVAL : PEND_NONE);
            end else if (is_op) begin
              state_d = S_OP;
            end else if (is_term) begin
              state_d = S_EVAL;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            acc_d      = '0;
            ovf_d      = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      S_PUSH, S_OP, S_EVAL: begin
        // bytes arriving while a command is outstanding are lost, the command is not
        if (rx_ready) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end
        if (cmd_ready) begin
          if (state_q == S_PUSH) begin
            acc_d   = '0;
            pend_d  = PEND_NONE;
            state_d = (pend_q == PEND_OP) ? S_OP : ((pend_q == PEND_EVAL) ? S_EVAL : S_IDLE);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      op_q       <= 2'd0;
      pend_q     <= PEND_NONE;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      op_q       <= op_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    busy      = (state_q == S_PUSH) || (state_q == S_OP) || (state_q == S_EVAL);
    cmd_valid = busy;
    cmd_type  = (state_q == S_OP) ? 2'd1 : ((state_q == S_EVAL) ? 2'd2 : 2'd0);
    cmd_op    = (state_q == S_OP) ? op_q : 2'd0;
    cmd_data  = (state_q == S_PUSH) ? acc_q : '0;
    err       = err_q;
    err_code  = err_code_q;
  end

endmodule

// File: tb/tb_rpn_rx_sequencer.sv
// tb/tb_rpn_rx_sequencer.sv - scoreboard bench for rpn_rx_sequencer
// Stimulus queues expected commands/errors; a negedge monitor pops and compares them.
module tb_rpn_rx_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [1:0]  cmd_type;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  rpn_rx_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .err(err), .err_code(err_code), .busy(busy)
  );

  always #4 clk = ~clk;

  // {follow, type, op, data}; follow=1 means it must handshake the cycle after the previous one
  logic [20:0] exp_cmd_q[$];
  logic [1:0]  exp_err_q[$];
  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int v0 = 0, v1 = 0;
  int tmo = 0;
  bit done = 0;
  bit rst_at_edge = 0;

  always @(posedge clk) rst_at_edge = rst;

  int cyc = 0;
  int last_hs = -10;
  bit stalled = 0;
  logic [1:0] st_type, st_op;
  logic [15:0] st_data;
  logic [20:0] e;
  logic [1:0] ec;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stalled = 0;
    end else if (rst_at_edge) begin
      checks++;
      if (cmd_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || err_code !== 2'd0 || cmd_data !== 16'd0) begin
        failures++;
        $display("FAIL reset_state: valid=%b err=%b busy=%b code=%0d data=%0d, required all 0",
                 cmd_valid, err, busy, err_code, cmd_data);
      end
      stalled = 0;
    end else begin
      if (stalled) begin
        checks++;
        if (cmd_valid !== 1'b1 || busy !== 1'b1 || cmd_type !== st_type || cmd_op !== st_op || cmd_data !== st_data) begin
          failures++;
          $display("FAIL stall_stable: valid=%b busy=%b type=%0d op=%0d data=%0d, required 1 1 %0d %0d %0d",
                   cmd_valid, busy, cmd_type, cmd_op, cmd_data, st_type, st_op, st_data);
        end
      end
      if (cmd_valid) valid_cycles++;
      if (cmd_valid && cmd_ready) begin
        checks++;
        if (exp_cmd_q.size() == 0) begin
          failures++;
          $display("FAIL cmd_unexpected: type=%0d op=%0d data=%0d, required no command", cmd_type, cmd_op, cmd_data);
        end else begin
          e = exp_cmd_q.pop_front();
          if (cmd_type !== e[19:18] || cmd_op !== e[17:16] || cmd_data !== e[15:0]) begin
            failures++;
            $display("FAIL cmd_value: type=%0d op=%0d data=%0d, required %0d %0d %0d",
                     cmd_type, cmd_op, cmd_data, e[19:18], e[17:16], e[15:0]);
          end
          if (e[20]) begin
            checks++;
            if (last_hs != cyc - 1) begin
              failures++;
              $display("FAIL follow_on_gap: gap=%0d cycles, required 1", cyc - last_hs);
            end
          end
        end
        last_hs = cyc;
      end
      stalled = cmd_valid && !cmd_ready;
      st_type = cmd_type; st_op = cmd_op; st_data = cmd_data;
      if (err) begin
        checks++;
        if (exp_err_q.size() == 0) begin
          failures++;
          $display("FAIL err_unexpected: code=%0d, required no error", err_code);
        end else begin
          ec = exp_err_q.pop_front();
          if (err_code !== ec) begin
            failures++;
            $display("FAIL err_code: got %0d, required %0d", err_code, ec);
          end
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_cmd_q.size() != 0 || exp_err_q.size() != 0) begin
        failures++;
        $display("FAIL drain: cmds left=%0d errs left=%0d, required 0 0", exp_cmd_q.size(), exp_err_q.size());
      end
      checks++;
      if (v1 - v0 != 4) begin
        failures++;
        $display("FAIL valid_cycles_t1: got %0d, required 4", v1 - v0);
      end
      checks++;
      if (tmo != 0) begin
        failures++;
        $display("FAIL timeout: %0d waits expired, required 0", tmo);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic exp_cmd(input bit f, input logic [1:0] t, input logic [1:0] o, input logic [15:0] d);
    exp_cmd_q.push_back({f, t, o, d});
  endtask

  task automatic exp_err(input logic [1:0] c);
    exp_err_q.push_back(c);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit wait_idle);
    int n = 0;
    while (wait_idle && busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) tmo++;
    rx_data = b; rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic settle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) tmo++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // "12 34+\n" with ready high: four single-cycle commands
    v0 = valid_cycles;
    exp_cmd(0, 2'd0, 2'd0, 16'd12);
    exp_cmd(0, 2'd0, 2'd0, 16'd34);
    exp_cmd(1, 2'd1, 2'd0, 16'd0);
    exp_cmd(0, 2'd2, 2'd0, 16'd0);
    send_str("12 34+\n");
    settle();
    v1 = valid_cycles;

    // overflow boundary at 65535/65536, then overflow ending on an operator
    exp_cmd(0, 2'd0, 2'd0, 16'd65535);
    exp_err(2'd2);
    send_str("65535 65536 ");
    settle();
    exp_cmd(0, 2'd0, 2'd0, 16'd3);
    send_str("3 ");
    settle();
    exp_err(2'd2);
    exp_cmd(0, 2'd1, 2'd0, 16'd0);
    send_str("99999+");
    settle();

    // stalled PUSH 7, overrun byte, release into PUSH then OP '*'
    cmd_ready = 1'b0;
    exp_cmd(0, 2'd0, 2'd0, 16'd7);
    exp_cmd(1, 2'd1, 2'd2, 16'd0);
    send_str("7*");
    repeat (10) @(posedge clk);
    #1;
    exp_err(2'd3);
    send_byte(8'h33, 1'b0);
    repeat (2) @(posedge clk);
    #1 cmd_ready = 1'b1;
    settle();

    // bad char discards the pending number
    exp_err(2'd1);
    exp_cmd(0, 2'd0, 2'd0, 16'd5);
    exp_cmd(1, 2'd2, 2'd0, 16'd0);
    send_str("4a5\n");
    settle();

    // reset while PUSH is stalled drops it
    cmd_ready = 1'b0;
    send_str("8 ");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    exp_cmd(0, 2'd0, 2'd0, 16'd9);
    exp_cmd(1, 2'd2, 2'd0, 16'd0);
    send_str("9\n");
    settle();

    // lone terminator and '-' after ignored spaces
    exp_cmd(0, 2'd2, 2'd0, 16'd0);
    send_str("\n");
    settle();
    exp_cmd(0, 2'd1, 2'd1, 16'd0);
    send_str("  -");
    settle();

    for (int n = 0; n < 100 && (exp_cmd_q.size() != 0 || exp_err_q.size() != 0); n++)
      @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
